// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the UART receive monitor.
package uart_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam int         DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Serial input and decoded-byte outputs of the UART receive monitor.
interface uart_rx_monitor_if #(
  parameter int DATA_BITS = 8
);

  logic                 uart_tx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 line_end;
  logic                 busy;
  logic [15:0]          char_count;

  modport master (
    input  uart_tx,
    output rx_data, rx_valid, frame_err, line_end, busy, char_count
  );

  modport slave (
    output uart_tx,
    input  rx_data, rx_valid, frame_err, line_end, busy, char_count
  );

endinterface

// File: rtl/uart_rx_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver that decodes a monitored TX line into bytes, framing errors and counts.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_monitor_if.master   bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] LF_CODE = DATA_BITS'(ASCII_LF);

  logic                 w_s_rx;
  state_e               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_fill;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_line_end;
  logic [15:0]          r_char_count;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.uart_tx),
    .o_q   (w_s_rx)
  );

  // The synchronizer holds its reset value for two cycles; r_fill marks when s_rx reflects the real line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_baud       <= '0;
      r_idx        <= '0;
      r_fill       <= 2'd0;
      r_armed      <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_line_end   <= 1'b0;
      r_char_count <= 16'd0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_line_end  <= 1'b0;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;

      case (r_state)
        IDLE: begin
          if (!r_armed) begin
            r_state <= WAIT_IDLE;
          end else if (!w_s_rx) begin
            r_state <= START;
            r_baud  <= '0;
          end
        end
        START: begin
          if (r_baud == HALF_LAST) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= w_s_rx ? IDLE : DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            r_idx  <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (w_s_rx) begin
              r_rx_data    <= r_shift;
              r_rx_valid   <= 1'b1;
              r_line_end   <= (r_shift == LF_CODE);
              r_char_count <= r_char_count + 16'd1;
              r_state      <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_s_rx && (r_fill == 2'd2)) begin
            r_state <= IDLE;
            r_armed <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // LSB arrives first, so each new bit enters at the top and shifts toward bit 0.
  always_ff @(posedge clk) begin
    if ((r_state == DATA) && (r_baud == BAUD_LAST)) begin
      r_shift <= {w_s_rx, r_shift[DATA_BITS-1:1]};
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.line_end   = r_line_end;
  assign bus.busy       = (r_state != IDLE);
  assign bus.char_count = r_char_count;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor at 434 and 16 clocks per bit.
module tb_uart_rx_monitor;

  localparam int CPB_A = 434;
  localparam int CPB_B = 16;

  typedef struct packed {
    logic        err;
    logic [7:0]  data;
    logic        lf;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  uart_rx_monitor_if #(.DATA_BITS(8)) if_a ();
  uart_rx_monitor_if #(.DATA_BITS(8)) if_b ();

  uart_rx_monitor #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (if_a)
  );

  uart_rx_monitor #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic [15:0] m_cnt[2];
  logic [7:0]  m_last[2];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tx(input int which, input logic v);
    if (which == 0) if_a.uart_tx = v;
    else            if_b.uart_tx = v;
  endtask

  task automatic hold(input int which, input logic v, input int n);
    set_tx(which, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int which);
    m_cnt[which]  = 16'd0;
    m_last[which] = 8'h00;
  endtask

  // Expectation is queued before the frame is driven; stop_ok=0 expects a framing error.
  task automatic send(input int which, input logic [7:0] b, input logic stop_ok,
                      input int extra_low, input int idle_bits);
    int   cpb;
    exp_t e;
    cpb = (which == 0) ? CPB_A : CPB_B;
    if (stop_ok) begin
      m_cnt[which]  = m_cnt[which] + 16'd1;
      m_last[which] = b;
      e = '{err: 1'b0, data: b, lf: (b == 8'h0A), cnt: m_cnt[which]};
    end else begin
      e = '{err: 1'b1, data: m_last[which], lf: 1'b0, cnt: m_cnt[which]};
    end
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    hold(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(which, b[i], cpb);
    hold(which, stop_ok, cpb);
    if (!stop_ok) hold(which, 1'b0, extra_low * cpb);
    hold(which, 1'b1, idle_bits * cpb);
  endtask

  always @(negedge clk) begin
    if (rst_n_a && (if_a.rx_valid || if_a.frame_err)) begin
      chk("a_excl", 32'(if_a.rx_valid & if_a.frame_err), 32'd0);
      if (q_a.size() == 0) begin
        chk("a_unexpected", 32'({if_a.frame_err, if_a.rx_valid}), 32'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_kind", 32'(if_a.frame_err), 32'(e_a.err));
        chk("a_data", 32'(if_a.rx_data), 32'(e_a.data));
        chk("a_lf",   32'(if_a.line_end), 32'(e_a.lf));
        chk("a_cnt",  32'(if_a.char_count), 32'(e_a.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b && (if_b.rx_valid || if_b.frame_err)) begin
      chk("b_excl", 32'(if_b.rx_valid & if_b.frame_err), 32'd0);
      if (q_b.size() == 0) begin
        chk("b_unexpected", 32'({if_b.frame_err, if_b.rx_valid}), 32'd0);
      end else begin
        e_b = q_b.pop_front();
        chk("b_kind", 32'(if_b.frame_err), 32'(e_b.err));
        chk("b_data", 32'(if_b.rx_data), 32'(e_b.data));
        chk("b_lf",   32'(if_b.line_end), 32'(e_b.lf));
        chk("b_cnt",  32'(if_b.char_count), 32'(e_b.cnt));
      end
    end
  end

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    if_a.uart_tx = 1'b1;
    if_b.uart_tx = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  32'(if_a.rx_data), 32'd0);
    chk("rst_valid", 32'(if_a.rx_valid), 32'd0);
    chk("rst_ferr",  32'(if_a.frame_err), 32'd0);
    chk("rst_lend",  32'(if_a.line_end), 32'd0);
    chk("rst_busy",  32'(if_a.busy), 32'd0);
    chk("rst_cnt",   32'(if_a.char_count), 32'd0);
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    hold(0, 1'b1, 10);

    // Single byte with one idle bit
    send(0, 8'h55, 1'b1, 0, 1);
    @(negedge clk);
    chk("55_busy", 32'(if_a.busy), 32'd0);
    chk("55_cnt",  32'(if_a.char_count), 32'd1);
    chk("55_drain", 32'(q_a.size()), 32'd0);

    // Start glitch shorter than half a bit
    hold(0, 1'b0, 100);
    hold(0, 1'b1, CPB_A);
    @(negedge clk);
    chk("glitch_busy", 32'(if_a.busy), 32'd0);
    chk("glitch_cnt",  32'(if_a.char_count), 32'd1);

    // Framing error, then a good byte
    send(0, 8'hA3, 1'b0, 2, 1);
    chk("ferr_keep", 32'(if_a.rx_data), 32'h55);
    send(0, 8'h41, 1'b1, 0, 1);
    chk("41_data", 32'(if_a.rx_data), 32'h41);
    chk("41_drain", 32'(q_a.size()), 32'd0);

    // Back-to-back "Hi\n" from a fresh reset
    rst_n_a = 1'b0;
    repeat (5) @(posedge clk); #1;
    rst_n_a = 1'b1;
    model_reset(0);
    hold(0, 1'b1, 10);
    send(0, 8'h48, 1'b1, 0, 0);
    send(0, 8'h69, 1'b1, 0, 0);
    send(0, 8'h0A, 1'b1, 0, 1);
    @(negedge clk);
    chk("hi_cnt", 32'(if_a.char_count), 32'd3);
    chk("hi_drain", 32'(q_a.size()), 32'd0);

    // Reset in the middle of a 0xFF frame
    hold(0, 1'b0, CPB_A);
    hold(0, 1'b1, 3 * CPB_A);
    rst_n_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_data", 32'(if_a.rx_data), 32'd0);
    chk("mid_rst_cnt",  32'(if_a.char_count), 32'd0);
    chk("mid_rst_busy", 32'(if_a.busy), 32'd0);
    @(posedge clk); #1;
    rst_n_a = 1'b1;
    model_reset(0);
    hold(0, 1'b1, CPB_A);
    send(0, 8'h0F, 1'b1, 0, 1);
    @(negedge clk);
    chk("0f_cnt", 32'(if_a.char_count), 32'd1);
    chk("0f_data", 32'(if_a.rx_data), 32'h0F);

    // Fast instance: line held low through reset release
    if_b.uart_tx = 1'b0;
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    hold(1, 1'b0, 300);
    @(negedge clk);
    chk("low_busy", 32'(if_b.busy), 32'd1);
    chk("low_cnt",  32'(if_b.char_count), 32'd0);
    @(posedge clk); #1;
    hold(1, 1'b1, 2 * CPB_B);
    send(1, 8'h00, 1'b1, 0, 1);
    send(1, 8'hFF, 1'b1, 0, 1);
    @(negedge clk);
    chk("b_cnt2", 32'(if_b.char_count), 32'd2);

    // Counter rollover via preload
    force dut_b.r_char_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut_b.r_char_count;
    m_cnt[1] = 16'hFFFF;
    send(1, 8'h3A, 1'b1, 0, 1);
    @(negedge clk);
    chk("wrap_cnt", 32'(if_b.char_count), 32'd0);

    repeat (2 * CPB_A) @(posedge clk);
    chk("final_drain_a", 32'(q_a.size()), 32'd0);
    chk("final_drain_b", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
